single_mips_instr_encoder: RTL and testbench

Sequential instruction encoder and loader for the single-cycle MIPS core. It accepts field-level instruction descriptions over a valid/ready handshake and assembles 32-bit MIPS words for the opcodes the core's main decoder supports: R-type, lw, sw, beq, addi and j. It buffers the words in a small FIFO and writes them sequentially into instruction memory through a write port with backpressure. It is used by the test harness and boot logic to populate instruction memory before the core runs.

---
 rtl/single_mips_instr_encoder.sv | 141 ++++++++++++++
 tb/tb_single_mips_instr_encoder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_mips_instr_encoder.sv
// Field-level MIPS instruction encoder that streams encoded words
// into instruction memory through a small write FIFO.
module single_mips_instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic              FINISH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [2:0]        INSTR_KIND,
    input  logic [4:0]        RS,
    input  logic [4:0]        RT,
    input  logic [4:0]        RD,
    input  logic [5:0]        FUNCT,
    input  logic [15:0]       IMM,
    input  logic [25:0]       TARGET,
    output logic              IMEM_WR_EN,
    input  logic              IMEM_WR_READY,
    output logic [ADDR_W-1:0] IMEM_WR_ADDR,
    output logic [31:0]       IMEM_WR_DATA,
    output logic [ADDR_W:0]   WORD_COUNT,
    output logic              ILLEGAL_ERR,
    output logic              DONE
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] issue_addr;
    logic              exhausted;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              full, empty;
    logic              legal, accept, push, pop, last, start_ok;
    logic [31:0]       word;

    assign full     = (count == FIFO_DEPTH[PTR_W:0]);
    assign empty    = (count == '0);
    assign accept   = IN_VALID && IN_READY;
    assign push     = accept && legal;
    assign pop      = IMEM_WR_EN && IMEM_WR_READY;
    assign last     = (issue_addr == '1);
    assign start_ok = (state == IDLE) && START;

    assign IMEM_WR_EN   = !empty;
    assign IMEM_WR_ADDR = empty ? '0 : fifo_addr[rd_ptr];
    assign IMEM_WR_DATA = empty ? '0 : fifo_data[rd_ptr];

    always_comb begin
        legal = 1'b1;
        word  = '0;
        unique case (INSTR_KIND)
            3'd0: word = {6'b000000, RS, RT, RD, 5'b00000, FUNCT};
            3'd1: word = {6'b100011, RS, RT, IMM};
            3'd2: word = {6'b101011, RS, RT, IMM};
            3'd3: word = {6'b000100, RS, RT, IMM};
            3'd4: word = {6'b001000, RS, RT, IMM};
            3'd5: word = {6'b000010, TARGET};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        DONE      = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) state_nxt = RUN;
            end
            RUN: begin
                IN_READY = !full && !exhausted;
                if ((push && last) || FINISH) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (empty) begin
                    DONE      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            issue_addr  <= '0;
            exhausted   <= 1'b0;
            ILLEGAL_ERR <= 1'b0;
            WORD_COUNT  <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                issue_addr  <= START_ADDR;
                exhausted   <= 1'b0;
                ILLEGAL_ERR <= 1'b0;
                WORD_COUNT  <= '0;
            end else begin
                // The last address is never incremented so it cannot wrap.
                if (push && !last) issue_addr <= issue_addr + 1'b1;
                if (push && last) exhausted <= 1'b1;
                if (accept && !legal) ILLEGAL_ERR <= 1'b1;
                if (pop) WORD_COUNT <= WORD_COUNT + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= issue_addr;
            fifo_data[wr_ptr] <= word;
        end
    end

endmodule

// File: tb/tb_single_mips_instr_encoder.sv
// Directed bench for the MIPS instruction encoder and loader.
module tb_single_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  instr_kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        wr_en;
    logic        wr_ready = 1'b1;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  word_count;
    logic        illegal_err;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;
    logic [7:0]  log_addr [$];
    logic [31:0] log_data [$];

    single_mips_instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .CLK(clk), .RST(rst_n), .START(start), .START_ADDR(start_addr),
        .FINISH(finish), .IN_VALID(in_valid), .IN_READY(in_ready),
        .INSTR_KIND(instr_kind), .RS(rs), .RT(rt), .RD(rd),
        .FUNCT(funct), .IMM(imm), .TARGET(target),
        .IMEM_WR_EN(wr_en), .IMEM_WR_READY(wr_ready),
        .IMEM_WR_ADDR(wr_addr), .IMEM_WR_DATA(wr_data),
        .WORD_COUNT(word_count), .ILLEGAL_ERR(illegal_err), .DONE(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_en && wr_ready) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (rst_n && done) done_cnt++;
        if (rst_n && done && wr_en) overlap_cnt++;
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
        overlap_cnt = 0;
    endtask

    task automatic set_desc(input logic [2:0] k, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d,
                            input logic [5:0] f, input logic [15:0] i,
                            input logic [25:0] tg);
        instr_kind = k; rs = s; rt = t; rd = d;
        funct = f; imm = i; target = tg;
    endtask

    task automatic do_start(input logic [7:0] a);
        start_addr = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic send();
        bit got = 0;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200; n++) begin
            if (done_cnt > 0) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, wr_en, done, illegal_err} !== 4'b0 ||
            word_count !== 9'd0 || wr_addr !== 8'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b en=%b done=%b ill=%b wc=%0d a=%h d=%h expected all 0",
                     in_ready, wr_en, done, illegal_err, word_count, wr_addr, wr_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_encodings();
        logic [7:0]  ea [6];
        logic [31:0] ed [6];
        ed = '{32'h20080005, 32'h8D280004, 32'h012A4020,
               32'hAFBF0008, 32'h1100FFFF, 32'h08000010};
        ea = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        clear_log();
        wr_ready = 1'b1;
        do_start(8'h10);
        set_desc(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0); send();
        set_desc(3'd1, 5'd9, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0); send();
        set_desc(3'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'd0, 26'd0); send();
        set_desc(3'd2, 5'd29, 5'd31, 5'd0, 6'd0, 16'd8, 26'd0); send();
        set_desc(3'd3, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0); send();
        set_desc(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10); send();
        do_finish();
        wait_done();
        checks++;
        if (log_addr.size() !== 6) begin
            errors++;
            $display("FAIL enc_count: got %0d expected 6", log_addr.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= log_addr.size()) begin
                errors++;
                $display("FAIL enc_missing[%0d]: got none expected %h", i, ed[i]);
            end else if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
                errors++;
                $display("FAIL enc_word[%0d]: got %h@%h expected %h@%h",
                         i, log_data[i], log_addr[i], ed[i], ea[i]);
            end
        end
        checks++;
        if (word_count !== 9'd6) begin
            errors++;
            $display("FAIL enc_wc: got %0d expected 6", word_count);
        end
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL done_overlap: got %0d expected 0", overlap_cnt);
        end
    endtask

    task automatic test_backpressure();
        int  i = 0;
        bit  a;
        clear_log();
        wr_ready = 1'b0;
        do_start(8'h20);
        set_desc(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) begin
                i++;
                set_desc(3'd4, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i), 26'd0);
            end
        end
        @(negedge clk);
        checks++;
        if (i !== 4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: got %0d rdy=%b expected 4 rdy=0", i, in_ready);
        end
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'h20 || wr_data !== 32'h20000000) begin
            errors++;
            $display("FAIL bp_head: got en=%b %h@%h expected 1 20000000@20",
                     wr_en, wr_data, wr_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr !== 8'h20 || wr_data !== 32'h20000000) begin
            errors++;
            $display("FAIL bp_stable: got %h@%h expected 20000000@20", wr_data, wr_addr);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        for (int c = 0; c < 50 && i < 6; c++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) begin
                i++;
                set_desc(3'd4, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i), 26'd0);
            end
        end
        in_valid = 1'b0;
        do_finish();
        wait_done();
        checks++;
        if (log_addr.size() !== 6) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 6", log_addr.size());
        end
        for (int k = 0; k < 6 && k < log_addr.size(); k++) begin
            checks++;
            if (log_addr[k] !== 8'(8'h20 + k) ||
                log_data[k] !== (32'h20000000 | (32'(k) << 16) | 32'(k))) begin
                errors++;
                $display("FAIL bp_word[%0d]: got %h@%h expected %h@%h", k,
                         log_data[k], log_addr[k],
                         32'h20000000 | (32'(k) << 16) | 32'(k), 8'(8'h20 + k));
            end
        end
    endtask

    task automatic test_illegal();
        clear_log();
        wr_ready = 1'b1;
        do_start(8'h30);
        set_desc(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0); send();
        set_desc(3'd6, 5'd3, 5'd3, 5'd3, 6'd3, 16'd3, 26'd3); send();
        set_desc(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'd2, 26'd0); send();
        do_finish();
        wait_done();
        checks++;
        if (illegal_err !== 1'b1 || word_count !== 9'd2) begin
            errors++;
            $display("FAIL ill_flag: got ill=%b wc=%0d expected 1 2", illegal_err, word_count);
        end
        checks++;
        if (log_addr.size() !== 2 || log_addr[0] !== 8'h30 || log_addr[1] !== 8'h31 ||
            log_data[0] !== 32'h20010001 || log_data[1] !== 32'h20020002) begin
            errors++;
            $display("FAIL ill_writes: got %0d writes expected 20010001@30 20020002@31",
                     log_addr.size());
        end
        do_start(8'h40);
        @(negedge clk);
        checks++;
        if (illegal_err !== 1'b0 || word_count !== 9'd0) begin
            errors++;
            $display("FAIL ill_clear: got ill=%b wc=%0d expected 0 0", illegal_err, word_count);
        end
        @(posedge clk); #1;
        clear_log();
        do_finish();
        wait_done();
    endtask

    task automatic test_exhaustion();
        int i = 0;
        bit a;
        clear_log();
        wr_ready = 1'b1;
        do_start(8'hFE);
        set_desc(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 10 && i < 3; c++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) begin
                i++;
                set_desc(3'd4, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i), 26'd0);
            end
        end
        @(negedge clk);
        checks++;
        if (i !== 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ex_accepts: got %0d rdy=%b expected 2 rdy=0", i, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done();
        checks++;
        if (log_addr.size() !== 2 || log_addr[0] !== 8'hFE || log_addr[1] !== 8'hFF ||
            log_data[1] !== 32'h20010001 || word_count !== 9'd2) begin
            errors++;
            $display("FAIL ex_writes: got %0d writes wc=%0d expected FE,FF wc=2",
                     log_addr.size(), word_count);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        wr_ready = 1'b1;
        do_start(8'h50);
        start_addr = 8'h70;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        set_desc(3'd4, 5'd0, 5'd3, 5'd0, 6'd0, 16'd7, 26'd0);
        in_valid = 1'b1;
        finish = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fin_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        finish = 1'b0;
        wait_done();
        checks++;
        if (log_addr.size() !== 1 || log_addr[0] !== 8'h50 ||
            log_data[0] !== 32'h20030007 || word_count !== 9'd1) begin
            errors++;
            $display("FAIL fin_write: got %0d writes wc=%0d expected 20030007@50 wc=1",
                     log_addr.size(), word_count);
        end
    endtask

    task automatic test_mid_reset();
        clear_log();
        wr_ready = 1'b0;
        do_start(8'h60);
        set_desc(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0); send();
        set_desc(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'd2, 26'd0); send();
        set_desc(3'd4, 5'd0, 5'd3, 5'd0, 6'd0, 16'd3, 26'd0); send();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL mr_queued: got en=%b expected 1", wr_en);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || word_count !== 9'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mr_async: got en=%b wc=%0d rdy=%b expected 0 0 0",
                     wr_en, word_count, in_ready);
        end
        wr_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (log_addr.size() !== 0 || in_ready !== 1'b0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL mr_after: got writes=%0d rdy=%b done=%0d expected 0 0 0",
                     log_addr.size(), in_ready, done_cnt);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_backpressure();
        test_illegal();
        test_exhaustion();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
